router_input_port: RTL and testbench

- Per-direction input stage of the 5-port mesh router, instantiated once each for L, N, E, W and S.
- Buffers incoming flits in a synchronous FIFO and decodes the flit at the head.
- Drives the arbiter's per-port request, flit_id and length inputs, then drains one packet per grant toward the crossbar.
- Sits directly upstream of the router's 6-state one-hot arbiter and its per-port timers.

---
 rtl/router_pkg.sv | 33 +++
 rtl/router_input_port_sync_fifo.sv | 53 +++++
 rtl/router_input_port.sv | 108 ++++++++++
 tb/tb_router_input_port.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the mesh router input stage: flit ids, defaults,
// arbiter port indices and the input-port state encoding.
package router_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 12;

  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  // Bit positions of each direction in the arbiter's one-hot state vector
  localparam int L = 1;
  localparam int N = 2;
  localparam int E = 3;
  localparam int W = 4;
  localparam int S = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } port_state_e;

  function automatic logic is_header(input logic [2:0] id);
    return id == HEADER;
  endfunction

  function automatic logic is_tail(input logic [2:0] id);
    return id == TAIL;
  endfunction

endpackage

// File: rtl/router_input_port_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a combinational head read.
// A push while full is refused even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; clearing the pointers makes old contents invisible
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/router_input_port.sv
// Per-direction router input stage: buffers flits, requests the arbiter for
// each packet headed by a HEADER flit and drains it on grant until the TAIL.
module router_input_port
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3+DATA_W-1:0] in_flit,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                grant,
  output logic                req,
  output logic [2:0]          flit_id,
  output logic [LEN_W-1:0]    length,
  output logic [3+DATA_W-1:0] out_flit,
  output logic                out_valid,
  output logic                drop_err
);

  localparam int FW = 3 + DATA_W;

  port_state_e       state_q, state_d;
  logic [FW-1:0]     head;
  logic [2:0]        head_id;
  logic              full, empty;
  logic              push, pop;
  logic              req_c, xfer_c, drop_c;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_id = head[FW-1 -: 3];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    req_c   = 1'b0;
    xfer_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (is_header(head_id)) begin
            state_d = REQ;
          end else begin
            // Orphan flit with no packet context: discard it
            pop    = 1'b1;
            drop_c = 1'b1;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (grant) begin
          state_d = XFER;
        end
      end
      XFER: begin
        req_c = 1'b1;
        // Losing grant mid-packet just stalls; the packet resumes on re-grant
        if (grant && !empty) begin
          xfer_c = 1'b1;
          pop    = 1'b1;
          if (is_tail(head_id)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is forced low while rst is high
  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready;
  assign req       = req_c && !rst;
  assign out_valid = xfer_c && !rst;
  assign drop_err  = drop_c && !rst;
  assign flit_id   = (!rst && !empty) ? head_id : 3'b000;
  assign length    = (!rst && !empty && is_header(head_id)) ? head[LEN_W-1:0] : '0;
  assign out_flit  = out_valid ? head : '0;

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port: directed packets push expected
// flits into a queue; a monitor compares every out_valid beat in order.
module tb_router_input_port;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [34:0] out_flit;
  logic        out_valid;
  logic        drop_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          beats = 0;
  int          drops = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_exp;

  router_input_port #(.DATA_W(32), .DEPTH(8), .LEN_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .grant    (grant),
    .req      (req),
    .flit_id  (flit_id),
    .length   (length),
    .out_flit (out_flit),
    .out_valid(out_valid),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mk(input logic [2:0] id, input logic [31:0] pl);
    return {id, pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic push(input logic [2:0] id, input logic [31:0] pl, input bit fwd);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    in_flit  = mk(id, pl);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 id %0h", id);
    end else if (fwd) begin
      exp_q.push_back(mk(id, pl));
    end
  endtask

  task automatic wait_req_low(input string name, input int bound);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (req && n < bound);
    chk(name, 64'(req), 64'd0);
  endtask

  task automatic wait_beats(input string name, input int target, input int bound);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (beats < target && n < bound);
    chk(name, 64'(beats), 64'(target));
  endtask

  // Monitor: every presented beat must match the next expected flit
  always @(negedge clk) begin
    if (!rst && drop_err) drops++;
    if (!rst && out_valid) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected no beat", out_flit);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("beat", 64'(out_flit), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_flit  = '0;
    grant    = 1'b0;

    // Reset then idle
    sample();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    step();
    rst = 1'b0;
    sample();
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_req", 64'(req), 64'd0);
    chk("idle_flit_id", 64'(flit_id), 64'd0);
    chk("idle_length", 64'(length), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_drop_err", 64'(drop_err), 64'd0);
    chk("idle_out_flit", 64'(out_flit), 64'd0);
    step();

    // Single packet
    push(HEADER, 32'h0000_0005, 1'b1);
    sample();
    chk("p1_req_before", 64'(req), 64'd0);
    step();
    push(BODY, 32'hB0D1_0001, 1'b1);
    sample();
    chk("p1_req", 64'(req), 64'd1);
    chk("p1_flit_id", 64'(flit_id), 64'(HEADER));
    chk("p1_length", 64'(length), 64'd5);
    step();
    push(TAIL, 32'h7A11_0001, 1'b1);
    grant = 1'b1;
    sample();
    chk("p1_xfer_delay", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("p1_consec_beat", 64'(out_valid), 64'd1);
    end
    sample();
    chk("p1_req_after_tail", 64'(req), 64'd0);
    chk("p1_queue_drained", 64'(exp_q.size()), 64'd0);
    step();
    grant = 1'b0;

    // Pre-emption mid-packet
    push(HEADER, 32'h0000_0006, 1'b1);
    for (int i = 1; i <= 4; i++) push(BODY, 32'hB200_0000 + 32'(i), 1'b1);
    push(TAIL, 32'h7A11_0002, 1'b1);
    grant = 1'b1;
    base  = beats;
    wait_beats("pre_first_beats", base + 2, 20);
    step();
    grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("pre_gap_valid", 64'(out_valid), 64'd0);
      chk("pre_gap_req", 64'(req), 64'd1);
    end
    chk("pre_gap_head", 64'(flit_id), 64'(BODY));
    step();
    grant = 1'b1;
    wait_req_low("pre_req_drop", 20);
    chk("pre_beat_count", 64'(beats), 64'(base + 6));
    chk("pre_queue_drained", 64'(exp_q.size()), 64'd0);
    step();
    grant = 1'b0;

    // Full FIFO: 8 accepted, 9th held until the cycle after the first pop
    push(HEADER, 32'h0000_0009, 1'b1);
    for (int i = 1; i <= 7; i++) push(BODY, 32'hB300_0000 + 32'(i), 1'b1);
    sample();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step();
    in_flit  = mk(TAIL, 32'h7A11_0003);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("full_hold_ready", 64'(in_ready), 64'd0);
      step();
    end
    grant = 1'b1;
    n = 0;
    do begin
      sample();
      n++;
      if (!out_valid) step();
    end while (!out_valid && n < 10);
    chk("full_first_pop_valid", 64'(out_valid), 64'd1);
    chk("full_ready_on_pop", 64'(in_ready), 64'd0);
    step();
    sample();
    chk("full_ready_after_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    exp_q.push_back(mk(TAIL, 32'h7A11_0003));
    wait_req_low("full_req_drop", 30);
    chk("full_queue_drained", 64'(exp_q.size()), 64'd0);
    step();
    grant = 1'b0;

    // Orphan flits are discarded with a single drop_err pulse each
    d0 = drops;
    push(BODY, 32'hDEAD_0001, 1'b0);
    sample();
    chk("orph_drop_pulse", 64'(drop_err), 64'd1);
    chk("orph_req", 64'(req), 64'd0);
    sample();
    chk("orph_drop_end", 64'(drop_err), 64'd0);
    chk("orph_req_after", 64'(req), 64'd0);
    step();
    push(3'b000, 32'hDEAD_0002, 1'b0);
    sample();
    chk("orph_other_id_pulse", 64'(drop_err), 64'd1);
    step();
    push(HEADER, 32'h0000_0003, 1'b1);
    push(BODY, 32'hB400_0001, 1'b1);
    push(TAIL, 32'h7A11_0004, 1'b1);
    sample();
    chk("orph_hdr_req", 64'(req), 64'd1);
    chk("orph_drop_count", 64'(drops), 64'(d0 + 2));
    step();
    grant = 1'b1;
    wait_req_low("orph_req_drop", 20);
    chk("orph_queue_drained", 64'(exp_q.size()), 64'd0);
    step();
    grant = 1'b0;

    // Reset mid-packet with 3 flits still queued
    push(HEADER, 32'h0000_0004, 1'b1);
    for (int i = 1; i <= 4; i++) push(BODY, 32'hB500_0000 + 32'(i), 1'b1);
    grant = 1'b1;
    base  = beats;
    wait_beats("mrst_beats", base + 2, 20);
    step();
    rst = 1'b1;
    exp_q.delete();
    sample();
    chk("mrst_req_in_rst", 64'(req), 64'd0);
    chk("mrst_ready_in_rst", 64'(in_ready), 64'd0);
    chk("mrst_valid_in_rst", 64'(out_valid), 64'd0);
    chk("mrst_id_in_rst", 64'(flit_id), 64'd0);
    step();
    rst   = 1'b0;
    grant = 1'b0;
    sample();
    chk("mrst_req_after", 64'(req), 64'd0);
    chk("mrst_ready_after", 64'(in_ready), 64'd1);
    chk("mrst_empty_id", 64'(flit_id), 64'd0);
    step();
    push(HEADER, 32'h0000_0002, 1'b1);
    push(BODY, 32'hB600_0001, 1'b1);
    push(TAIL, 32'h7A11_0006, 1'b1);
    sample();
    chk("mrst_new_req", 64'(req), 64'd1);
    chk("mrst_new_length", 64'(length), 64'd2);
    step();
    grant = 1'b1;
    wait_req_low("mrst_req_drop", 20);
    chk("mrst_queue_drained", 64'(exp_q.size()), 64'd0);
    step();
    grant = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
